// File: rtl/uart_tx_cfg.sv
// UART transmitter with a small write-side FIFO, runtime bit-period prescaler,
// optional odd/even parity and selectable 1 or 2 stop bits.
module uart_tx_cfg #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int PRESC_WIDTH = 6
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DATA_WIDTH-1:0]         P_DATA,
  input  logic                          DATA_VALID,
  output logic                          DATA_READY,
  input  logic                          PAR_EN,
  input  logic                          PAR_TYP,
  input  logic                          STOP2,
  input  logic [PRESC_WIDTH-1:0]        PRESCALE,
  output logic                          TX_OUT,
  output logic                          Busy,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_CNT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  logic [DATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]          r_cnt;

  state_t                 r_state, w_state_nxt;
  logic [PRESC_WIDTH-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [PRESC_WIDTH-1:0] r_presc, w_presc_nxt;
  logic [IW-1:0]          r_bit_idx, w_bit_idx_nxt;
  logic [DATA_WIDTH-1:0]  r_shift, w_shift_nxt;
  logic                   r_par_bit, w_par_bit_nxt;
  logic                   r_par_en, w_par_en_nxt;
  logic                   r_stop2, w_stop2_nxt;
  logic                   r_tx, w_tx_nxt;

  logic                   w_push, w_pop, w_load, w_tick, w_not_empty;
  logic [PRESC_WIDTH-1:0] w_presc_eff;
  logic [DATA_WIDTH-1:0]  w_head;

  assign DATA_READY  = (r_cnt != CW'(FIFO_DEPTH));
  assign w_not_empty = (r_cnt != '0);
  assign w_push      = DATA_VALID && DATA_READY;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_presc_eff = (PRESCALE == '0) ? PRESC_WIDTH'(1) : PRESCALE;
  assign w_tick      = (r_bit_cnt == '0);
  assign w_pop       = w_load;

  assign TX_OUT   = r_tx;
  assign Busy     = (r_state != S_IDLE);
  assign FIFO_CNT = r_cnt;

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= P_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_presc   <= PRESC_WIDTH'(1);
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
      r_par_en  <= 1'b0;
      r_stop2   <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_presc   <= w_presc_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_par_bit <= w_par_bit_nxt;
      r_par_en  <= w_par_en_nxt;
      r_stop2   <= w_stop2_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  // TX_OUT is computed here for the bit that starts at the coming edge.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = w_tick ? (r_presc - 1'b1) : (r_bit_cnt - 1'b1);
    w_presc_nxt   = r_presc;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_par_bit_nxt = r_par_bit;
    w_par_en_nxt  = r_par_en;
    w_stop2_nxt   = r_stop2;
    w_tx_nxt      = r_tx;
    w_load        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        w_load   = w_not_empty;
      end
      S_START: begin
        if (w_tick) begin
          w_state_nxt   = S_DATA;
          w_bit_idx_nxt = '0;
          w_tx_nxt      = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_bit_idx == IW'(DATA_WIDTH - 1)) begin
            w_state_nxt = r_par_en ? S_PARITY : S_STOP1;
            w_tx_nxt    = r_par_en ? r_par_bit : 1'b1;
          end else begin
            w_shift_nxt   = r_shift >> 1;
            w_tx_nxt      = r_shift[1];
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_state_nxt = S_STOP1;
          w_tx_nxt    = 1'b1;
        end
      end
      S_STOP1: begin
        if (w_tick) begin
          w_state_nxt = r_stop2 ? S_STOP2 : S_IDLE;
          w_tx_nxt    = 1'b1;
          w_load      = !r_stop2 && w_not_empty;
        end
      end
      S_STOP2: begin
        if (w_tick) begin
          w_state_nxt = S_IDLE;
          w_tx_nxt    = 1'b1;
          w_load      = w_not_empty;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase

    // Pop the head word and capture its frame settings, back-to-back or from idle.
    if (w_load) begin
      w_state_nxt   = S_START;
      w_tx_nxt      = 1'b0;
      w_shift_nxt   = w_head;
      w_par_bit_nxt = (^w_head) ^ PAR_TYP;
      w_par_en_nxt  = PAR_EN;
      w_stop2_nxt   = STOP2;
      w_presc_nxt   = w_presc_eff;
      w_bit_cnt_nxt = w_presc_eff - 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: a line monitor decodes every frame and
// compares it cycle by cycle against words queued when they were accepted.
module tb_uart_tx_cfg;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       DATA_READY;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       STOP2;
  logic [5:0] PRESCALE;
  logic       TX_OUT;
  logic       Busy;
  logic [2:0] FIFO_CNT;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] expQ [$];

  uart_tx_cfg #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .PRESC_WIDTH(6)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .DATA_READY(DATA_READY), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .STOP2(STOP2), .PRESCALE(PRESCALE), .TX_OUT(TX_OUT), .Busy(Busy),
    .FIFO_CNT(FIFO_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Offers a word, waits for acceptance and queues it as expected line output.
  task automatic applyStimulus(input logic [7:0] d);
    int guard = 0;
    P_DATA     = d;
    DATA_VALID = 1'b1;
    while (DATA_READY !== 1'b1 && guard < 500) begin
      tick();
      guard++;
    end
    checkOutput("pushTimeout", guard < 500, 1);
    tick();
    expQ.push_back(d);
  endtask

  task automatic waitIdle();
    int guard = 0;
    while ((Busy !== 1'b0 || FIFO_CNT !== 3'd0) && guard < 5000) begin
      tick();
      guard++;
    end
    checkOutput("idleTimeout", guard < 5000, 1);
  endtask

  // Line monitor: frame settings are taken as driven when the start bit appears.
  logic       monPrevTx = 1'b1;
  logic [7:0] monData;
  logic [15:0] monBits;
  int         monN, monPresc, monOnes;
  logic       monAborted, monPe, monPt, monS2;

  initial begin
    forever begin
      @(negedge CLK);
      if (RST === 1'b1) begin
        monPrevTx = 1'b1;
      end else if (monPrevTx === 1'b1 && TX_OUT === 1'b0) begin
        monPresc = (PRESCALE == 6'd0) ? 1 : int'(PRESCALE);
        monPe = PAR_EN;
        monPt = PAR_TYP;
        monS2 = STOP2;
        checkOutput("frameExpected", expQ.size() != 0, 1);
        if (expQ.size() == 0) begin
          monPrevTx = 1'b0;
        end else begin
          monData = expQ.pop_front();
          monOnes = $countones(monData);
          monBits = '0;
          monBits[0] = 1'b0;
          for (int j = 0; j < 8; j++) monBits[1+j] = monData[j];
          monN = 9;
          if (monPe) begin
            monBits[monN] = monPt ? (monOnes % 2 == 0) : (monOnes % 2 == 1);
            monN++;
          end
          monBits[monN] = 1'b1;
          monN++;
          if (monS2) begin
            monBits[monN] = 1'b1;
            monN++;
          end
          monAborted = 1'b0;
          for (int i = 0; i < monN * monPresc; i++) begin
            if (i > 0) @(negedge CLK);
            if (RST === 1'b1) begin
              monAborted = 1'b1;
              break;
            end
            checkOutput("frameTx", TX_OUT, monBits[i / monPresc]);
            checkOutput("frameBusy", Busy, 1);
          end
          monPrevTx = monAborted ? 1'b1 : TX_OUT;
        end
      end else begin
        monPrevTx = TX_OUT;
      end
    end
  end

  int startCyc;

  initial begin
    RST = 1'b1; P_DATA = '0; DATA_VALID = 1'b0;
    PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; PRESCALE = 6'd4;
    tick(2);
    checkOutput("rstTx", TX_OUT, 1);
    checkOutput("rstBusy", Busy, 0);
    checkOutput("rstCnt", FIFO_CNT, 0);
    checkOutput("rstReady", DATA_READY, 1);
    RST = 1'b0;
    tick();

    $display("[TB] 0xA5, even parity, prescale 4");
    PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; PRESCALE = 6'd4;
    applyStimulus(8'hA5);
    DATA_VALID = 1'b0;
    checkOutput("t1PushCnt", FIFO_CNT, 1);
    checkOutput("t1PushTx", TX_OUT, 1);
    checkOutput("t1PushBusy", Busy, 0);
    tick();
    checkOutput("t1StartTx", TX_OUT, 0);
    checkOutput("t1StartBusy", Busy, 1);
    checkOutput("t1PopCnt", FIFO_CNT, 0);
    tick(43);
    checkOutput("t1LastBusy", Busy, 1);
    tick();
    checkOutput("t1EndBusy", Busy, 0);
    checkOutput("t1EndTx", TX_OUT, 1);

    $display("[TB] 0x00, odd parity, two stops, prescale 0");
    PAR_TYP = 1'b1; STOP2 = 1'b1; PRESCALE = 6'd0;
    applyStimulus(8'h00);
    DATA_VALID = 1'b0;
    tick();
    checkOutput("t2StartTx", TX_OUT, 0);
    tick(11);
    checkOutput("t2LastBusy", Busy, 1);
    tick();
    checkOutput("t2EndBusy", Busy, 0);

    $display("[TB] six words held on the input");
    PAR_EN = 1'b0; STOP2 = 1'b0; PRESCALE = 6'd2;
    applyStimulus(8'h01);
    startCyc = cyc + 1;
    for (int w = 2; w <= 5; w++) applyStimulus(8'(w));
    checkOutput("t3FullCnt", FIFO_CNT, 4);
    checkOutput("t3FullReady", DATA_READY, 0);
    applyStimulus(8'h06);
    DATA_VALID = 1'b0;
    checkOutput("t3SixthAccept", cyc - startCyc, 21);
    waitIdle();
    checkOutput("t3BusySpan", cyc - startCyc, 120);

    $display("[TB] push offered on a full FIFO during a pop");
    PRESCALE = 6'd1;
    applyStimulus(8'h11);
    for (int w = 8'h12; w <= 8'h15; w++) applyStimulus(8'(w));
    P_DATA = 8'hEE;
    DATA_VALID = 1'b1;
    tick(6);
    checkOutput("t4StillFull", FIFO_CNT, 4);
    tick();
    checkOutput("t4AfterPop", FIFO_CNT, 3);
    DATA_VALID = 1'b0;
    waitIdle();

    $display("[TB] prescale change mid-frame");
    PRESCALE = 6'd4;
    applyStimulus(8'h3C);
    startCyc = cyc + 1;
    applyStimulus(8'hC3);
    DATA_VALID = 1'b0;
    tick(10);
    PRESCALE = 6'd8;
    waitIdle();
    checkOutput("t5BusySpan", cyc - startCyc, 120);
    checkOutput("allWordsSent", expQ.size(), 0);

    $display("[TB] reset during data bit 3");
    PRESCALE = 6'd4;
    applyStimulus(8'h55);
    applyStimulus(8'h77);
    applyStimulus(8'h99);
    DATA_VALID = 1'b0;
    tick(15);
    checkOutput("t6QueuedCnt", FIFO_CNT, 2);
    checkOutput("t6MidTx", TX_OUT, 0);
    RST = 1'b1;
    tick();
    checkOutput("t6RstTx", TX_OUT, 1);
    checkOutput("t6RstBusy", Busy, 0);
    checkOutput("t6RstCnt", FIFO_CNT, 0);
    checkOutput("t6RstReady", DATA_READY, 1);
    expQ.delete();
    RST = 1'b0;
    tick(60);
    checkOutput("t6QuietBusy", Busy, 0);
    checkOutput("t6QuietTx", TX_OUT, 1);
    checkOutput("t6QuietCnt", FIFO_CNT, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
- Parametrised successor to the single-word UART transmitter.
- Adds a write-side FIFO with valid/ready handshake, a runtime bit-period prescaler, and selectable 1 or 2 stop bits.
- Keeps the configurable odd/even parity.
- Sits between the system controller (or register file) and the TX pin, on a single clock domain.

Parameters:
- DATA_WIDTH, 8: bits per frame payload.
- FIFO_DEPTH, 4: words buffered; power of two, minimum 2.
- PRESC_WIDTH, 6: width of the PRESCALE port.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- P_DATA  in  DATA_WIDTH  word to transmit.
- DATA_VALID  in  1  write request.
- DATA_READY  out  1  FIFO can accept a word.
- PAR_EN  in  1  enable parity bit.
- PAR_TYP  in  1  parity type: 0 = even, 1 = odd.
- STOP2  in  1  0 = one stop bit, 1 = two stop bits.
- PRESCALE  in  PRESC_WIDTH  CLK cycles per bit; 0 is treated as 1.
- TX_OUT  out  1  serial line, idle high.
- Busy  out  1  frame in progress.
- FIFO_CNT  out  $clog2(FIFO_DEPTH)+1  words currently buffered.

Behaviour:
- Reset: one clock, synchronous, active-high. On any edge with RST=1:
  - TX_OUT=1, Busy=0, FIFO_CNT=0, DATA_READY=1.
  - FIFO pointers cleared and contents discarded.
  - FSM forced to IDLE.
  - Reset mid-frame aborts the frame; TX_OUT returns high at that edge.
- Handshake:
  - DATA_READY = (FIFO_CNT != FIFO_DEPTH), combinational from count only.
  - A push occurs on an edge with DATA_VALID && DATA_READY.
  - When full, a push is refused even if a pop happens on the same edge.
  - Push and pop on the same edge leave FIFO_CNT unchanged.
- Config latch: PAR_EN, PAR_TYP, STOP2 and max(PRESCALE,1) are latched at the pop edge. Changes mid-frame have no effect until the next frame.
- Parity: computed at the pop edge over the popped word. Even parity gives an even total number of ones across data plus parity bit; odd parity gives an odd total.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: TX_OUT=1, Busy=0. On an edge where FIFO is non-empty, pop the head word, go to START.
  - START: TX_OUT=0.
  - DATA: DATA_WIDTH bits, LSB first.
  - PARITY: present only if PAR_EN was latched.
  - STOP1: TX_OUT=1.
  - STOP2: TX_OUT=1; present only if STOP2 was latched.
- Bit timing: every state except IDLE lasts exactly P latched cycles. A down-counter reloads on each bit transition.
- TX_OUT is registered: driven from the state/shift register, no combinational path from inputs.
- Busy=1 in every state except IDLE.
- Latency: word pushed at edge k into an empty FIFO while IDLE → pop at edge k+1 → TX_OUT=0 from edge k+1.
- Frame length = P × (1 + DATA_WIDTH + PAR_EN + 1 + STOP2) cycles.
- Back-to-back: if the FIFO is non-empty at the last cycle of the final stop bit, the next pop and START happen on that edge with no IDLE cycle. Busy stays 1 throughout.
- Pointer wrap-around: modulo FIFO_DEPTH. The count distinguishes full from empty.

Test Plan:
1. Reset, then push 0xA5 with PRESCALE=4, PAR_EN=1, PAR_TYP=0, STOP2=0 → TX_OUT = 0, 1,0,1,0,0,1,0,1, 0 (parity), 1, each bit held 4 cycles. Start bit begins one edge after the push. Busy high for 44 cycles.
2. PAR_TYP=1, STOP2=1, PRESCALE=0, push 0x00 → parity bit 1; two stop bits; 12 cycles total at 1 cycle per bit.
3. Hold DATA_VALID with 6 words (0x01 to 0x06) while a frame runs → DATA_READY drops when FIFO_CNT=4. All 6 words are sent in order; stop of one frame is followed directly by the start of the next, with Busy never low in between.
4. With the FIFO full, pop and offered push on the same edge → push refused, FIFO_CNT goes 4→3, refused word never transmitted.
5. Change PRESCALE from 4 to 8 mid-frame → current frame stays at 4 cycles per bit; next frame uses 8.
6. Assert RST during DATA bit 3 with 2 words queued → next edge TX_OUT=1, Busy=0, FIFO_CNT=0; no further frames are sent.
